// File: rtl/huffman_packer.sv
// -----------------------------------------------------------------------------
// huffman_packer
//
// Back end of the Huffman code generator. A six-entry code table (HC1..HC6
// with masks M1..M6) is captured on the code_valid strobe. Incoming gray-level
// symbols 1..6 are then replaced by their variable-length codes, and those
// codes are packed MSB-first into bytes. On end-of-stream the final partial
// byte is zero-padded and a one-cycle done pulse follows the last byte.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-low reset
//   code_valid  in   one-cycle table load strobe
//   HC1..HC6    in   [7:0] code for symbol k (low len bits meaningful)
//   M1..M6      in   [7:0] mask for symbol k, len = popcount(M), legal 1..5
//   sym_valid   in   symbol offered
//   sym_data    in   [7:0] symbol value, legal 1..6
//   sym_last    in   last symbol of the stream (qualified by handshake)
//   sym_ready   out  symbol accepted this cycle when sym_valid is high
//   out_valid   out  packed byte available
//   out_data    out  [7:0] packed byte, first code bit in bit 7
//   out_ready   in   downstream takes the byte
//   done        out  one-cycle pulse after the last byte of a stream
//   err         out  sticky illegal-symbol flag, cleared by reset/table load
//
// Optional feature (macro HUFF_PACK_BITCNT_EN):
//   bit_total   out  [15:0] saturating count of code bits appended since the
//                    last table load or done; absent when the macro is undefined.
// -----------------------------------------------------------------------------
module huffman_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [7:0]  HC1,
  input  logic [7:0]  HC2,
  input  logic [7:0]  HC3,
  input  logic [7:0]  HC4,
  input  logic [7:0]  HC5,
  input  logic [7:0]  HC6,
  input  logic [7:0]  M1,
  input  logic [7:0]  M2,
  input  logic [7:0]  M3,
  input  logic [7:0]  M4,
  input  logic [7:0]  M5,
  input  logic [7:0]  M6,
  input  logic        sym_valid,
  input  logic [7:0]  sym_data,
  input  logic        sym_last,
  output logic        sym_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        done,
  output logic        err
`ifdef HUFF_PACK_BITCNT_EN
  ,
  output logic [15:0] bit_total
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Code length of a table entry; 0 marks an unusable entry (popcount 0 or >5).
  function automatic logic [2:0] code_len(input logic [7:0] m);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, m[i]};
    end
    if (ones == 4'd0 || ones > 4'd5) begin
      code_len = 3'd0;
    end else begin
      code_len = ones[2:0];
    end
  endfunction

  state_e      state_q, state_d;
  logic [11:0] acc_q, acc_d;       // pending bits, oldest bit at [11]
  logic [3:0]  bitcnt_q, bitcnt_d; // 0..12 pending bits
  logic        err_q, err_d;
  logic [7:0]  hc_q [6];
  logic [7:0]  m_q  [6];

  logic        load_ok;
  logic        sym_fire;
  logic        byte_fire;
  logic        sym_in_range;
  logic [7:0]  sel_hc;
  logic [7:0]  sel_m;
  logic [2:0]  sym_len;
  logic        sym_legal;
  logic [11:0] code_ext;
  logic [3:0]  shamt;

  // Handshake-facing outputs depend only on registered state, so neither
  // valid/ready has a combinational path from the opposite side.
  assign sym_ready = (state_q == S_RUN) && (bitcnt_q < 4'd8);
  assign out_valid = ((state_q == S_RUN || state_q == S_FLUSH) && (bitcnt_q >= 4'd8)) ||
                     ((state_q == S_FLUSH) && (bitcnt_q != 4'd0));
  assign out_data  = acc_q[11:4];
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

  assign sym_fire  = sym_valid && sym_ready;
  assign byte_fire = out_valid && out_ready;

  // A reload is only safe when no packed bits depend on the old table.
  assign load_ok = code_valid &&
                   ((state_q == S_IDLE) || (state_q == S_DONE) ||
                    ((state_q == S_RUN) && (bitcnt_q == 4'd0)));

  // Symbol lookup
  always_comb begin
    sel_hc       = 8'h00;
    sel_m        = 8'h00;
    sym_in_range = 1'b1;
    case (sym_data)
      8'd1: begin sel_hc = hc_q[0]; sel_m = m_q[0]; end
      8'd2: begin sel_hc = hc_q[1]; sel_m = m_q[1]; end
      8'd3: begin sel_hc = hc_q[2]; sel_m = m_q[2]; end
      8'd4: begin sel_hc = hc_q[3]; sel_m = m_q[3]; end
      8'd5: begin sel_hc = hc_q[4]; sel_m = m_q[4]; end
      8'd6: begin sel_hc = hc_q[5]; sel_m = m_q[5]; end
      default: sym_in_range = 1'b0;
    endcase
  end

  assign sym_len   = code_len(sel_m);
  assign sym_legal = sym_in_range && (sym_len != 3'd0);
  // Masking strips any junk above the code length before the code is placed.
  assign code_ext  = {4'h0, sel_hc & sel_m};
  // Place the new code directly behind the pending bits; bitcnt <= 7 and
  // len <= 5 whenever a symbol is accepted, so this never underflows.
  assign shamt     = 4'd12 - bitcnt_q - {1'b0, sym_len};

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    bitcnt_d = bitcnt_q;
    err_d    = err_q;

    if (load_ok) begin
      err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (code_valid) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (sym_fire) begin
          if (sym_legal) begin
            acc_d    = acc_q | (code_ext << shamt);
            bitcnt_d = bitcnt_q + {1'b0, sym_len};
          end else begin
            err_d = 1'b1;
          end
          if (sym_last) begin
            state_d = S_FLUSH;
          end
        end else if (byte_fire) begin
          acc_d    = {acc_q[3:0], 8'h00};
          bitcnt_d = bitcnt_q - 4'd8;
        end
      end

      S_FLUSH: begin
        if (bitcnt_q == 4'd0) begin
          state_d = S_DONE;
        end else if (byte_fire) begin
          if (bitcnt_q >= 4'd8) begin
            acc_d    = {acc_q[3:0], 8'h00};
            bitcnt_d = bitcnt_q - 4'd8;
            if (bitcnt_q == 4'd8) begin
              state_d = S_DONE;
            end
          end else begin
            // Padded tail: bits below the pending ones are already zero.
            acc_d    = 12'h000;
            bitcnt_d = 4'd0;
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_RUN;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and packing registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      acc_q    <= 12'h000;
      bitcnt_q <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      bitcnt_q <= bitcnt_d;
      err_q    <= err_d;
    end
  end

  // Code table
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 6; k++) begin
        hc_q[k] <= 8'h00;
        m_q[k]  <= 8'h00;
      end
    end else if (load_ok) begin
      hc_q[0] <= HC1;
      hc_q[1] <= HC2;
      hc_q[2] <= HC3;
      hc_q[3] <= HC4;
      hc_q[4] <= HC5;
      hc_q[5] <= HC6;
      m_q[0]  <= M1;
      m_q[1]  <= M2;
      m_q[2]  <= M3;
      m_q[3]  <= M4;
      m_q[4]  <= M5;
      m_q[5]  <= M6;
    end
  end

`ifdef HUFF_PACK_BITCNT_EN
  logic [15:0] bit_total_q, bit_total_d;
  logic [16:0] bit_sum;

  always_comb begin
    bit_total_d = bit_total_q;
    if (load_ok || state_q == S_DONE) begin
      bit_total_d = 16'h0000;
    end
    bit_sum = {1'b0, bit_total_d} + {14'd0, sym_len};
    if (sym_fire && sym_legal) begin
      bit_total_d = bit_sum[16] ? 16'hFFFF : bit_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_total_q <= 16'h0000;
    end else begin
      bit_total_q <= bit_total_d;
    end
  end

  assign bit_total = bit_total_q;
`else
  // Bit counter not built in this configuration.
`endif

endmodule

// File: tb/tb_huffman_packer.sv
module tb_huffman_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        code_valid = 1'b0;
  logic [7:0]  hc_t [6];
  logic [7:0]  m_t  [6];
  logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0]  M1, M2, M3, M4, M5, M6;
  logic        sym_valid = 1'b0;
  logic [7:0]  sym_data = 8'h00;
  logic        sym_last = 1'b0;
  logic        sym_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        done;
  logic        err;
`ifdef HUFF_PACK_BITCNT_EN
  logic [15:0] bit_total;
`endif

  assign HC1 = hc_t[0]; assign HC2 = hc_t[1]; assign HC3 = hc_t[2];
  assign HC4 = hc_t[3]; assign HC5 = hc_t[4]; assign HC6 = hc_t[5];
  assign M1  = m_t[0];  assign M2  = m_t[1];  assign M3  = m_t[2];
  assign M4  = m_t[3];  assign M5  = m_t[4];  assign M6  = m_t[5];

  huffman_packer dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .HC1        (HC1),
    .HC2        (HC2),
    .HC3        (HC3),
    .HC4        (HC4),
    .HC5        (HC5),
    .HC6        (HC6),
    .M1         (M1),
    .M2         (M2),
    .M3         (M3),
    .M4         (M4),
    .M5         (M5),
    .M6         (M6),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .sym_last   (sym_last),
    .sym_ready  (sym_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .done       (done),
    .err        (err)
`ifdef HUFF_PACK_BITCNT_EN
    ,
    .bit_total  (bit_total)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] sym_q [$];   // stream to send
  logic [7:0] exp_q [$];   // expected packed bytes
  int         exp_bits;    // legal code bits in the stream
  bit         model_err;   // expected sticky err

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Length of table entry k from its mask; 0 = unusable.
  function automatic int tlen(input int k);
    int pc;
    pc = $countones(m_t[k]);
    return (pc >= 1 && pc <= 5) ? pc : 0;
  endfunction

  // Reference model: concatenate the code bits of the stream, cut into bytes,
  // zero-pad the remainder.
  task automatic model();
    bit         bq [$];
    logic [7:0] byt;
    int         v, l;
    exp_q.delete();
    exp_bits = 0;
    foreach (sym_q[i]) begin
      v = int'(sym_q[i]);
      if (v >= 1 && v <= 6 && tlen(v - 1) > 0) begin
        l = tlen(v - 1);
        for (int b = l - 1; b >= 0; b--) bq.push_back(hc_t[v - 1][b]);
        exp_bits += l;
      end else begin
        model_err = 1'b1;
      end
    end
    while (bq.size() > 0) begin
      byt = 8'h00;
      for (int j = 7; j >= 0; j--) begin
        if (bq.size() > 0) byt[j] = bq.pop_front();
      end
      exp_q.push_back(byt);
    end
  endtask

  task automatic load_table();
    @(negedge clk);
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    model_err  = 1'b0;
    #1;
    check("load_sym_ready", sym_ready, 1);
    check("load_err_clear", err, 0);
  endtask

  // mode 0: out_ready=1; mode 1: random ready and random sym_valid gaps;
  // mode 2: out_ready held low 5 cycles once out_valid first rises.
  task automatic run_stream(input int mode, input string tag);
    int         idx = 0, got = 0, cyc = 0, stall = -1;
    int         last_byte = -100, last_sym = -100, done_cyc = -1, exp_done;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [15:0] bt_at_done = 16'h0000;
    model();
    while (done_cyc < 0 && cyc < 3000) begin
      @(negedge clk);
      if (idx < sym_q.size() && (mode != 1 || $urandom_range(0, 3) != 0)) begin
        sym_valid = 1'b1;
        sym_data  = sym_q[idx];
        sym_last  = (idx == sym_q.size() - 1);
      end else begin
        sym_valid = 1'b0;
        sym_data  = 8'($urandom);
        sym_last  = 1'($urandom);
      end
      case (mode)
        1: out_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (stall < 0 && out_valid) stall = 5;
          if (stall > 0) begin out_ready = 1'b0; stall--; end
          else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
      #1;
      if (prev_stall) begin
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_data"}, out_data, prev_data);
      end
      if (mode == 2 && !out_ready) check({tag, "_stall_sym_ready"}, sym_ready, 0);
      check({tag, "_ready_valid_excl"}, sym_ready & out_valid, 0);
      if (done) begin
        done_cyc = cyc;
`ifdef HUFF_PACK_BITCNT_EN
        bt_at_done = bit_total;
`endif
      end else begin
        if (out_valid && out_ready) begin
          if (got < exp_q.size()) check({tag, "_byte"}, out_data, exp_q[got]);
          got++;
          last_byte = cyc;
        end
        if (sym_valid && sym_ready) begin
          idx++;
          last_sym = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      cyc++;
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    check({tag, "_done_seen"}, done_cyc >= 0, 1);
    check({tag, "_byte_count"}, got, exp_q.size());
    check({tag, "_syms_taken"}, idx, sym_q.size());
    exp_done = (last_byte + 1 > last_sym + 2) ? last_byte + 1 : last_sym + 2;
    check({tag, "_done_timing"}, done_cyc, exp_done);
`ifdef HUFF_PACK_BITCNT_EN
    check({tag, "_bit_total"}, bt_at_done, exp_bits);
`endif
    check({tag, "_err"}, err, model_err);
    @(negedge clk);
    #1;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_back_to_run"}, sym_ready, 1);
`ifdef HUFF_PACK_BITCNT_EN
    check({tag, "_bit_total_clr"}, bit_total, 0);
`endif
  endtask

  function automatic logic [7:0] rand_sym();
    if ($urandom_range(0, 9) < 8) return 8'($urandom_range(1, 6));
    case ($urandom_range(0, 2))
      0:       return 8'd0;
      1:       return 8'd7;
      default: return 8'($urandom_range(8, 255));
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 6; k++) begin hc_t[k] = 8'h00; m_t[k] = 8'h00; end
    model_err = 1'b0;

    // Reset values
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_sym_ready", sym_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
`ifdef HUFF_PACK_BITCNT_EN
    check("rst_bit_total", bit_total, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("idle_sym_ready", sym_ready, 0);

    // Basic packing: expect 0x59, 0x60
    hc_t[0] = 8'h00; m_t[0] = 8'h01;
    hc_t[1] = 8'h02; m_t[1] = 8'h03;
    hc_t[2] = 8'h06; m_t[2] = 8'h07;
    load_table();
    sym_q = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3};
    run_stream(0, "basic");

    // Backpressure
    run_stream(2, "bp");

    // Max-length codes: 8 x 10101
    hc_t[5] = 8'h15; m_t[5] = 8'h1F;
    load_table();
    sym_q.delete();
    for (int i = 0; i < 8; i++) sym_q.push_back(8'd6);
    run_stream(0, "maxlen");

    // Illegal symbols, then err stays sticky over a clean stream
    sym_q = '{8'd1, 8'd0, 8'd9, 8'd2};
    run_stream(0, "illegal");
    sym_q = '{8'd2};
    run_stream(0, "sticky");

    // Empty flush on an illegal first symbol
    load_table();
    sym_q = '{8'd0};
    run_stream(0, "empty");

    // Reset mid-stream
    load_table();
    @(negedge clk); sym_valid = 1'b1; sym_data = 8'd1; sym_last = 1'b0;
    @(negedge clk); sym_data = 8'd0;
    @(negedge clk); sym_data = 8'd2;
    @(negedge clk); sym_valid = 1'b0;
    #1;
    check("mid_err_before_rst", err, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_sym_ready", sym_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sym_valid = 1'b1; sym_data = 8'd1;
      #1;
      check("mid_idle_sym_ready", sym_ready, 0);
    end
    sym_valid = 1'b0;
    load_table();
    sym_q = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3};
    run_stream(0, "post_rst");

    // Randomized tables and streams
    for (int it = 0; it < 24; it++) begin
      int n;
      if (it % 4 == 0) begin
        for (int k = 0; k < 6; k++) begin
          int r;
          r = $urandom_range(0, 7);
          if (r == 0)      m_t[k] = 8'h00;
          else if (r == 1) m_t[k] = 8'h3F;
          else             m_t[k] = 8'((1 << $urandom_range(1, 5)) - 1);
          hc_t[k] = 8'($urandom);
        end
        load_table();
      end
      n = $urandom_range(1, 20);
      sym_q.delete();
      for (int i = 0; i < n; i++) sym_q.push_back(rand_sym());
      run_stream(1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/huffman_packer.md
# huffman_packer

Downstream stage of the Huffman code generator. Latches the six-entry code table (HC1..HC6 / M1..M6) on `code_valid`, then maps a stream of gray-level symbols (1..6) to their variable-length codes. Packs the codes MSB-first into bytes, with valid/ready backpressure on both sides, and zero-pads the final byte on end-of-stream.

## Interface
- No parameters. Code length is fixed at ≤5 bits and the table is fixed at 6 entries.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `code_valid` in 1: one-cycle table-load strobe from the code generator.
- `HC1..HC6` in 8 each: Huffman code for symbol k. Only the low `len` bits are meaningful.
- `M1..M6` in 8 each: mask for symbol k.
  - Contiguous ones from bit 0.
  - `len` = popcount(M), range 1..5.
- `sym_valid` in 1: symbol offered.
- `sym_data` in 8: symbol value. Legal values are 1..6.
- `sym_last` in 1: marks the final symbol. Qualified by the `sym_valid`/`sym_ready` handshake.
- `sym_ready` out 1: block accepts the symbol this cycle.
- `out_valid` out 1: packed byte available.
- `out_data` out 8: packed byte. The first code bit is in bit 7.
- `out_ready` in 1: downstream accepts the byte.
- `done` out 1: one-cycle pulse after the last byte of a stream is taken.
- `err` out 1: sticky flag, set when an illegal symbol is received.

## Operation
- State machine: IDLE, RUN, FLUSH, DONE.
  - IDLE: no table loaded. `sym_ready`=0. `code_valid` loads all 12 table registers and moves to RUN.
  - RUN: normal packing.
    - `sym_ready` = (bitcnt < 8).
    - On symbol handshake: append HC[len-1:0], MSB first, behind the existing bits; bitcnt += len.
    - If `sym_last` is also set, move to FLUSH.
  - FLUSH: `sym_ready`=0.
    - bitcnt ≥ 8: present the full byte.
    - 0 < bitcnt < 8: present the remaining bits left-aligned, low bits zero. On handshake, bitcnt ← 0.
    - bitcnt = 0: move to DONE.
  - DONE: assert `done` for one cycle, then return to RUN with the table retained.
- Accumulator: 12 bits, bitcnt 0..12. The worst case is 7 pending bits + a 5-bit code.
- `out_valid` = (bitcnt ≥ 8) in RUN and FLUSH, plus (bitcnt > 0) in FLUSH.
- On byte handshake, remove the oldest 8 bits: bitcnt −= 8, or bitcnt ← 0 for the padded tail.
- `sym_ready` and a full-byte `out_valid` are mutually exclusive, so a symbol accept and a byte pop never happen in the same cycle.
- Illegal symbol (0 or 7..255) that handshakes:
  - Contributes no bits and sets `err`.
  - `sym_last` on it is still honoured.
  - `err` clears only on reset or table load.
- `code_valid` is honoured in IDLE, RUN with bitcnt = 0, and DONE. It is ignored in all other cases. A reload replaces the whole table.
- A mask with popcount 0 or > 5 is treated as an illegal symbol for that entry.

## Timing
- Reset values:
  - State IDLE.
  - bitcnt 0, accumulator 0, table 0.
  - `sym_ready`, `out_valid`, `done`, `err` all 0; `out_data` 0.
- Table load: RUN takes effect the cycle after `code_valid`, so `sym_ready` can rise one cycle after the strobe.
- A symbol accepted at edge N updates bitcnt at N. `out_valid` is visible in the cycle after N.
- `out_data` holds stable while `out_valid`=1 and `out_ready`=0.
- Sustained throughput: one symbol per cycle while bitcnt < 8, and one byte per cycle while bitcnt ≥ 8.
- `done` pulses exactly one cycle after the final byte handshake.
- If `sym_last` lands with bitcnt = 0 afterwards, FLUSH→DONE takes one cycle and no byte is emitted.
- Reset asserted mid-stream: pending bits are discarded and the block returns to IDLE, so the table must be reloaded.

## Configuration
- `HUFF_PACK_BITCNT_EN` defined:
  - Adds output port `bit_total` [15:0], which counts code bits appended since the last table load or `done`.
  - The count saturates at 16'hFFFF.
  - It clears to 0 on reset, table load and the `done` cycle.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Basic packing:
  - Load HC1=0/M1=1, HC2=2/M2=3, HC3=6/M3=7.
  - Send 1,2,3,1,2,3 with `sym_last` on the final symbol and `out_ready`=1.
  - Expect bytes 0x59 then 0x60, then `done` for 1 cycle. With the macro, `bit_total`=12.
- Backpressure:
  - Same stream as above, with `out_ready` held 0 for 5 cycles once `out_valid` rises.
  - Expect `out_data`=0x59 held stable, `sym_ready`=0 throughout, and no data lost.
- Max-length codes:
  - Set M=0x1F, HC=0x15 for symbol 6, then send 8 × symbol 6 with last.
  - Expect five bytes 0xAD,0x6B,0x5A,0xD6,0xB5, then `done`.
- Illegal symbol:
  - Send 1, 0, 9, 2 with last.
  - Expect `err`=1 and sticky, and output byte 0x40 (bits "0","10" padded).
- Reset mid-stream:
  - Drop `reset` after 3 symbols.
  - Expect all outputs 0 and IDLE (`sym_ready`=0 until the next `code_valid`).
- Empty flush: `sym_last` on a first-symbol illegal value gives no byte, `done` 1 cycle later, and `err`=1.
